// File: rtl/metaball_pkg.sv
// Shared Q15 constants, scan FSM state type and fixed-point helpers for the
// metaball frame scheduler and its shading datapath.
package metaball_pkg;

    localparam int          FRAC_BITS = 15;
    localparam logic [31:0] Q15_ONE   = 32'h0000_8000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_ACCUM,
        S_WRITE,
        S_MOVE
    } scan_state_t;

    function automatic logic [31:0] to_q15(input int v);
        return 32'(v) << FRAC_BITS;
    endfunction

endpackage

// File: rtl/metaball_field_acc.sv
// Serial saturating accumulator: one 32-bit unsigned addend per add_en cycle,
// clamping to all-ones on carry.
module metaball_field_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        add_en_i,
    input  logic [31:0] din_i,
    output logic [31:0] sum_o
);

    logic [31:0] sum_q, sum_d;
    logic [32:0] wide;

    // Once clamped, any further non-zero addend carries again, so the clamp is sticky.
    always_comb begin
        wide  = {1'b0, sum_q} + {1'b0, din_i};
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = '0;
        end else if (add_en_i) begin
            sum_d = wide[32] ? 32'hFFFF_FFFF : wide[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/metaball_scan_ctrl.sv
// Per-frame raster scheduler: broadcasts pixel coordinates to the evaluator
// bank, gathers their contributions and writes one thresholded bit per pixel.
module metaball_scan_ctrl
    import metaball_pkg::*;
#(
    parameter int          N_BALLS = 3,
    parameter int          DISP_W  = 32,
    parameter int          DISP_H  = 64,
    parameter logic [31:0] THRESH  = Q15_ONE,
    parameter int          AW      = $clog2(DISP_W * DISP_H)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    output logic                   ball_stb,
    output logic [31:0]            p_x,
    output logic [31:0]            p_y,
    input  logic [N_BALLS-1:0]     ball_vld,
    input  logic [32*N_BALLS-1:0]  ball_out,
    output logic                   mov_en,
    output logic                   fb_we,
    output logic [AW-1:0]          fb_addr,
    output logic                   fb_wdata,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int XW = (DISP_W  > 1) ? $clog2(DISP_W)  : 1;
    localparam int YW = (DISP_H  > 1) ? $clog2(DISP_H)  : 1;
    localparam int IW = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;

    scan_state_t   state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pending_q, pending_d;
    logic          guard_q;
    logic          overrun_q;
    logic [31:0]   px_q, py_q;
    logic          acc_clr, acc_add;
    logic [31:0]   acc_din, acc_sum;
    logic          last_x, last_pix;

    assign last_x   = (x_q == XW'(DISP_W - 1));
    assign last_pix = last_x && (y_q == YW'(DISP_H - 1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        acc_clr = 1'b0;
        acc_add = 1'b0;
        case (state_q)
            S_IDLE: begin
                x_d = '0;
                y_d = '0;
                if (frame_tick || pending_q) state_d = S_STROBE;
            end
            S_STROBE: begin
                acc_clr = 1'b1;
                idx_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Completion flags from the previous pixel linger until the strobe lands.
                if (!guard_q && (&ball_vld)) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                acc_add = 1'b1;
                if (idx_q == IW'(N_BALLS - 1)) state_d = S_WRITE;
                else                           idx_d   = idx_q + 1'b1;
            end
            S_WRITE: begin
                if (last_pix) begin
                    state_d = S_MOVE;
                end else begin
                    state_d = S_STROBE;
                    if (last_x) begin
                        x_d = '0;
                        y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_MOVE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One request may queue behind the running frame; a second one is dropped.
    always_comb begin
        pending_d = (state_q != S_IDLE) ? (pending_q | frame_tick) : 1'b0;
    end

    always_comb begin
        acc_din = '0;
        for (int i = 0; i < N_BALLS; i++) begin
            if (idx_q == IW'(i)) acc_din = ball_out[32*i +: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            guard_q   <= 1'b0;
            overrun_q <= 1'b0;
            px_q      <= '0;
            py_q      <= '0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            guard_q   <= (state_q == S_STROBE);
            overrun_q <= (state_q != S_IDLE) && frame_tick && pending_q;
            if (state_d == S_STROBE) begin
                px_q <= to_q15(int'(x_d));
                py_q <= to_q15(int'(y_d));
            end
        end
    end

    metaball_field_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (acc_clr),
        .add_en_i (acc_add),
        .din_i    (acc_din),
        .sum_o    (acc_sum)
    );

    assign ball_stb   = (state_q == S_STROBE);
    assign fb_we      = (state_q == S_WRITE);
    assign mov_en     = (state_q == S_MOVE);
    assign frame_done = (state_q == S_MOVE);
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign p_x        = px_q;
    assign p_y        = py_q;
    assign fb_addr    = AW'(y_q) * AW'(DISP_W) + AW'(x_q);
    assign fb_wdata   = fb_we && (acc_sum >= THRESH);

endmodule

// File: tb/tb_metaball_scan_ctrl.sv
// Scoreboard bench for metaball_scan_ctrl with stub evaluators of programmable delay.
module tb_metaball_scan_ctrl;

    localparam int NB   = 2;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
    localparam int AW   = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_tick;
    logic              ball_stb, mov_en, fb_we, fb_wdata, busy, frame_done, overrun;
    logic [31:0]       p_x, p_y;
    logic [NB-1:0]     ball_vld = '1;
    logic [32*NB-1:0]  ball_out = '0;
    logic [AW-1:0]     fb_addr;

    always #5 clk = ~clk;

    metaball_scan_ctrl #(
        .N_BALLS (NB),
        .DISP_W  (W),
        .DISP_H  (H),
        .THRESH  (32'h0000_8000),
        .AW      (AW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .ball_stb   (ball_stb),
        .p_x        (p_x),
        .p_y        (p_y),
        .ball_vld   (ball_vld),
        .ball_out   (ball_out),
        .mov_en     (mov_en),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_wdata   (fb_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    typedef struct {
        int          addr;
        bit          wdata;
        logic [31:0] px;
        logic [31:0] py;
        logic [31:0] sum;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_new, e_got;
    int          total = 0;
    int          bad   = 0;
    int          dly[NB];
    logic [31:0] cfg_out[NB];
    bit          rnd_mode;
    logic [31:0] pix_out[NB];
    int          cnt[NB];
    int          pix = 0;
    longint      cyc = 0;

    int     wr_in_frame = 0, wr_total = 0, stb_total = 0, frames = 0, ovr_cnt = 0;
    longint last_we_cyc = 0, last_mov_cyc = 0;
    int     last_addr = -1, gap_after_mov = -1;
    bit     waiting_stb = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 32'h5000));
            1:       return 32'($urandom_range(32'h3FF0, 32'h4010));
            2:       return $urandom;
            default: return {16'hFFFF, 16'($urandom)};
        endcase
    endfunction

    // Reference: plain unsigned sum of all contributions, clamped to 32 bits.
    function automatic logic [31:0] model_sum(input logic [31:0] v[NB]);
        longint s = 0;
        for (int i = 0; i < NB; i++) s += longint'({32'h0, v[i]});
        return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    function automatic int maxd();
        int m = 0;
        for (int i = 0; i < NB; i++) if (dly[i] > m) m = dly[i];
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Stub evaluators plus expectation push at every strobe.
    always @(posedge clk) begin
        if (rst) begin
            pix = 0;
            sb.delete();
        end else if (ball_stb) begin
            for (int i = 0; i < NB; i++) begin
                pix_out[i] = rnd_mode ? rnd_val() : cfg_out[i];
                ball_vld[i] <= 1'b0;
                cnt[i] = dly[i];
            end
            e_new.addr  = pix;
            e_new.sum   = model_sum(pix_out);
            e_new.wdata = (e_new.sum >= 32'h0000_8000);
            e_new.px    = 32'((pix % W) * 32768);
            e_new.py    = 32'((pix / W) * 32768);
            sb.push_back(e_new);
            pix = (pix + 1) % NPIX;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (!ball_vld[i]) begin
                    if (cnt[i] <= 1) begin
                        ball_vld[i]          <= 1'b1;
                        ball_out[32*i +: 32] <= pix_out[i];
                    end else begin
                        cnt[i] = cnt[i] - 1;
                    end
                end
            end
        end
    end

    // Monitor: compares every framebuffer write and frame-end pulse.
    always @(negedge clk) begin
        if (rst) begin
            wr_in_frame = 0;
            waiting_stb = 0;
        end else begin
            if (ball_stb) stb_total++;
            if (fb_we) begin
                chk("sb_has_entry", (sb.size() != 0), 1'b1);
                if (sb.size() != 0) begin
                    e_got = sb.pop_front();
                    chk("fb_addr", fb_addr, e_got.addr);
                    chk("fb_wdata", fb_wdata, e_got.wdata);
                    chk("p_x", p_x, e_got.px);
                    chk("p_y", p_y, e_got.py);
                    chk("acc_sum", u_dut.u_acc.sum_o, e_got.sum);
                end
                if (wr_in_frame > 0) chk("pixel_period", cyc - last_we_cyc, 5 + maxd());
                last_we_cyc = cyc;
                last_addr   = int'(fb_addr);
                wr_in_frame++;
                wr_total++;
            end
            if (mov_en || frame_done) begin
                chk("frame_done_eq_mov_en", frame_done, mov_en);
                if (mov_en) begin
                    chk("mov_after_last_write", cyc - last_we_cyc, 1);
                    chk("last_addr", last_addr, NPIX - 1);
                    chk("writes_per_frame", wr_in_frame, NPIX);
                    wr_in_frame  = 0;
                    frames++;
                    last_mov_cyc = cyc;
                    waiting_stb  = 1;
                end
            end
            if (ball_stb && waiting_stb) begin
                gap_after_mov = int'(cyc - last_mov_cyc);
                waiting_stb   = 0;
            end
            if (overrun) ovr_cnt++;
        end
    end

    task automatic pulse_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frames < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_reached", frames, target);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n = 0;
        while (wr_in_frame < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("writes_reached", wr_in_frame, target);
    endtask

    task automatic run_frame();
        int f0 = frames;
        pulse_tick();
        wait_frames(f0 + 1, 400);
        repeat (2) @(negedge clk);
        chk("idle_after_frame", busy, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_ball_stb"}, ball_stb, 1'b0);
        chk({tag, "_fb_we"}, fb_we, 1'b0);
        chk({tag, "_mov_en"}, mov_en, 1'b0);
        chk({tag, "_frame_done"}, frame_done, 1'b0);
        chk({tag, "_overrun"}, overrun, 1'b0);
        chk({tag, "_p_x"}, p_x, 32'h0);
        chk({tag, "_p_y"}, p_y, 32'h0);
        chk({tag, "_fb_addr"}, fb_addr, 0);
        chk({tag, "_fb_wdata"}, fb_wdata, 1'b0);
    endtask

    initial begin
        int f0, ovr0, w0, s0, n;
        rst        = 1'b1;
        frame_tick = 1'b0;
        dly        = '{3, 3};
        cfg_out    = '{32'h0000_4000, 32'h0000_4000};
        rnd_mode   = 0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("post_reset");

        run_frame();
        cfg_out = '{32'h0000_3FFF, 32'h0000_3FFF}; run_frame();
        cfg_out = '{32'h0000_4000, 32'h0000_3FFF}; run_frame();
        cfg_out = '{32'h0000_4000, 32'h0000_4000}; run_frame();
        cfg_out = '{32'hFFFF_0000, 32'h0002_0000}; run_frame();
        cfg_out = '{32'hFFFF_C000, 32'h0000_4000}; run_frame();
        rnd_mode = 1; run_frame(); run_frame();

        dly = '{2, 9};
        run_frame();

        dly  = '{3, 3};
        f0   = frames;
        ovr0 = ovr_cnt;
        pulse_tick();
        wait_writes(3, 100);
        pulse_tick();
        repeat (5) @(negedge clk);
        chk("busy_before_third_tick", busy, 1'b1);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("overrun_pulse", overrun, 1'b1);
        @(negedge clk);
        chk("overrun_one_cycle", overrun, 1'b0);
        wait_frames(f0 + 2, 600);
        chk("restart_gap", gap_after_mov, 2);
        repeat (60) @(negedge clk);
        chk("exactly_two_frames", frames, f0 + 2);
        chk("idle_after_two_frames", busy, 1'b0);
        chk("overrun_count", ovr_cnt - ovr0, 1);

        pulse_tick();
        wait_writes(5, 100);
        n = 0;
        while (!ball_stb && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_pixel5", ball_stb, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_outputs_zero("mid_frame_rst");
        rst = 1'b0;
        w0  = wr_total;
        s0  = stb_total;
        f0  = frames;
        repeat (30) @(negedge clk);
        chk("no_write_after_rst", wr_total - w0, 0);
        chk("no_strobe_after_rst", stb_total - s0, 0);
        chk("no_frame_after_rst", frames, f0);
        run_frame();
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/metaball_scan_ctrl.md
Name: metaball_scan_ctrl

Overview:
Frame scheduler for a bank of metaball field evaluators.
- Once per frame_tick it raster-scans every display pixel and broadcasts the pixel coordinate in Q15 to all evaluators.
- It strobes the evaluators, waits for every one to complete, then sums their contributions with saturation.
- The sum is thresholded and written to the framebuffer as one bit per pixel.
- After the last pixel it pulses mov_en once, so evaluator positions only change between frames.

Parameters:
N_BALLS, 3, number of metaball evaluators sharing the coordinate bus
DISP_W, 32, display width in pixels (integer)
DISP_H, 64, display height in pixels (integer)
THRESH, 32'h0000_8000, iso-surface threshold in Q15 unsigned (1.0)
AW, $clog2(DISP_W*DISP_H), framebuffer address width (11 at defaults)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle frame start request (60 Hz)
ball_stb  out  1  one-cycle start strobe to all evaluators (px_stb)
p_x  out  32  pixel x, Q15 (x<<15), stable from STROBE through WRITE
p_y  out  32  pixel y, Q15 (y<<15), same stability
ball_vld  in  N_BALLS  per-evaluator completion flags
ball_out  in  32*N_BALLS  per-evaluator contribution, Q15 unsigned, ball i at [32i+31:32i]
mov_en  out  1  one-cycle position-update pulse to all evaluators
fb_we  out  1  framebuffer write enable
fb_addr  out  AW  y*DISP_W + x
fb_wdata  out  1  1 when field sum >= THRESH
busy  out  1  high while not in IDLE
frame_done  out  1  one-cycle pulse, coincident with mov_en
overrun  out  1  one-cycle pulse when a tick is dropped

Behaviour:
- Reset:
  - All outputs 0; state IDLE; x=y=0; pending=0; accumulator=0.
  - rst in any state, including mid-frame, aborts the frame.
  - The cycle after rst, no fb_we and no ball_stb are issued.
- FSM states: IDLE, STROBE, WAIT, ACCUM, WRITE, MOVE.
- IDLE:
  - Go to STROBE when frame_tick or pending is set.
  - Clear pending on leaving; x=y=0.
- STROBE:
  - ball_stb=1 for exactly one cycle; accumulator cleared.
  - Go to WAIT.
- WAIT:
  - The first cycle is a guard cycle: ball_vld is ignored, because completion flags stay high from the previous pixel until the strobe is seen.
  - From the second cycle on, move to ACCUM in the cycle after &ball_vld==1 is sampled.
  - There is no timeout.
- ACCUM:
  - Lasts N_BALLS cycles, index i=0..N_BALLS-1, adding ball_out[i] to the 33-bit intermediate.
  - The result saturates to 32'hFFFF_FFFF on carry; saturation is sticky within the pixel.
  - ball_out is sampled during ACCUM, because evaluators hold their quotient while vld is high.
- WRITE:
  - fb_we=1 for one cycle, with fb_addr=y*DISP_W+x and fb_wdata=(sum>=THRESH).
  - If x==DISP_W-1 and y==DISP_H-1, go to MOVE.
  - Otherwise x wraps to 0 at DISP_W-1 and y increments; go to STROBE.
- MOVE:
  - mov_en=1 and frame_done=1 for one cycle; go to IDLE.
  - If pending is set, IDLE immediately leaves next cycle.
- Pixel latency: 1 (STROBE) + 1 (guard) + k (wait for vld) + N_BALLS (ACCUM) + 1 (WRITE) cycles.
- frame_tick while busy:
  - If pending==0, set pending.
  - If pending==1, pulse overrun for one cycle and drop the tick.
  - frame_tick in the MOVE cycle counts as busy.
- p_x/p_y are registered from x,y; they change only on the WRITE→STROBE or IDLE→STROBE transition.
- Address arithmetic is unsigned, AW bits; DISP_W and DISP_H need not be powers of two.

Decomposition:
- Package metaball_pkg:
  - Q15 constants: FRAC_BITS=15, Q15_ONE=32'h0000_8000.
  - scan_state_t enum.
  - Function to_q15(int).
- Natural sub-module: metaball_field_acc.
  - Serial saturating accumulator with clear, add_en and 32-bit sum.
  - Reused later for colour/gradient shading.
- The FSM and raster counters stay in metaball_scan_ctrl.

Test Plan:
All tests use DISP_W=4, DISP_H=2, N_BALLS=2, and stub evaluators: vld goes low the cycle after ball_stb and high after a programmable delay, and out is held while vld is high.
1. Reset, one frame_tick, both outs 32'h0000_4000, delay 3 → 8 writes, fb_addr 0..7 in order, fb_wdata=1 each; mov_en and frame_done high exactly once, the cycle after the 8th write.
2. Outs 32'h0000_3FFF each (sum 0x7FFE) → all fb_wdata=0; outs 0x4000 and 0x3FFF (sum 0x7FFF) → 0; 0x4000+0x4000 → 1.
3. Outs 32'hFFFF_0000 and 32'h0002_0000 → internal sum 32'hFFFF_FFFF, fb_wdata=1.
4. Ball0 delay 2, ball1 delay 9, both vld held high at strobe time → no ACCUM before ball1 vld; each pixel takes 1+1+9+2+1 cycles; the correct per-pixel out is written.
5. Second frame_tick at pixel 3 → frame 2 starts (ball_stb) 2 cycles after mov_en with no idle gap beyond IDLE; a third tick while pending → overrun one cycle, exactly 2 frames run.
6. rst during WAIT of pixel 5 → next cycle busy=0, all outputs 0; no fb_we until a new frame_tick; the new frame starts at fb_addr 0.
